mdu_unit: RTL and testbench

//   Multi-cycle multiply/divide unit with HI/LO registers, beside the ALU in the EX stage.

---
 rtl/mdu_unit.sv | 131 +++++++++++++
 tb/tb_mdu_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at issue and committed after a programmable busy window.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [2*WIDTH-1:0]   pending, pending_next;
    logic [WIDTH-1:0]     hi_next, lo_next;
    logic                 done_next;

    logic [2*WIDTH-1:0]   mul_s, mul_u;
    logic [WIDTH-1:0]     abs_a, abs_b, uq, ur, sq, sr, dq, dr;
    logic                 b_zero;

    // Sign-extended operands make the truncated 2W product the signed result.
    assign mul_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    assign mul_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    // Signed divide via magnitudes; most-negative / -1 wraps naturally.
    assign b_zero = (B == '0);
    assign abs_a  = A[WIDTH-1] ? -A : A;
    assign abs_b  = B[WIDTH-1] ? -B : B;
    assign uq     = b_zero ? '0 : abs_a / abs_b;
    assign ur     = b_zero ? '0 : abs_a % abs_b;
    assign sq     = (A[WIDTH-1] ^ B[WIDTH-1]) ? -uq : uq;
    assign sr     = A[WIDTH-1] ? -ur : ur;
    assign dq     = b_zero ? '0 : A / B;
    assign dr     = b_zero ? '0 : A % B;

    assign busy = (cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            HI      <= '0;
            LO      <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pending <= pending_next;
            HI      <= hi_next;
            LO      <= lo_next;
            done    <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pending_next = pending;
        hi_next      = HI;
        lo_next      = LO;
        done_next    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            state_next   = RUN;
                            cnt_next     = MULT_N;
                            pending_next = mul_s;
                        end
                        OP_MULTU: begin
                            state_next   = RUN;
                            cnt_next     = MULT_N;
                            pending_next = mul_u;
                        end
                        OP_DIV: begin
                            state_next   = RUN;
                            cnt_next     = DIV_N;
                            pending_next = b_zero ? {HI, LO} : {sr, sq};
                        end
                        OP_DIVU: begin
                            state_next   = RUN;
                            cnt_next     = DIV_N;
                            pending_next = b_zero ? {HI, LO} : {dr, dq};
                        end
                        OP_MTHI: hi_next = A;
                        OP_MTLO: lo_next = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    hi_next    = pending[2*WIDTH-1:WIDTH];
                    lo_next    = pending[WIDTH-1:0];
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: stimulus pushes expected {HI,LO},
// a monitor pops and compares whenever done pulses.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fails  = 0;
    logic [63:0] sb[$];

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("hi", {32'd0, HI}, {32'd0, e[63:32]});
                check("lo", {32'd0, LO}, {32'd0, e[31:0]});
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is visible.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n_exp,
                          input logic [63:0] exp, input bit inject);
        int n;
        sb.push_back(exp);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom_range(1, 4));
        A = $urandom;
        B = $urandom;
        n = 0;
        while (busy && n < 200) begin
            n++;
            if (inject && n == 3) begin
                start = 1'b1; op = 3'd5; A = 32'hDEAD;
            end else if (inject && n == 4) begin
                start = 1'b0; op = 3'd0;
            end
            @(negedge clk);
        end
        start = 1'b0; op = 3'd0;
        check("busy_cycles", 64'(n), 64'(n_exp));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, HI}, 64'd0);
        check("rst_lo", {32'd0, LO}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(3'd1, 32'hFFFFFFFD, 32'd5, 5, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 5, 64'h00000001_FFFFFFFE, 1'b0);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 10, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 10,
               64'h00000000_80000000, 1'b0);
        run_op(3'd4, 32'd5, 32'd0, 10, 64'h00000000_80000000, 1'b0);
        run_op(3'd4, 32'd100, 32'd7, 10, 64'h00000002_0000000E, 1'b0);
        run_op(3'd3, 32'd7, 32'hFFFFFFFE, 10, 64'h00000001_FFFFFFFD, 1'b0);
        run_op(3'd3, 32'd3, 32'd0, 10, 64'h00000001_FFFFFFFD, 1'b0);

        start = 1'b1; op = 3'd5; A = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        check("mthi_hi", {32'd0, HI}, 64'h1234);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        start = 1'b1; op = 3'd6; A = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", {32'd0, LO}, 64'h5678);
        check("mtlo_hi", {32'd0, HI}, 64'h1234);
        check("mtlo_busy", {63'd0, busy}, 64'd0);

        start = 1'b1; op = 3'd7; A = 32'hFFFF; B = 32'd9;
        @(negedge clk);
        start = 1'b1; op = 3'd0;
        @(negedge clk);
        start = 1'b0;
        check("nop_busy", {63'd0, busy}, 64'd0);
        check("nop_hilo", {HI, LO}, 64'h00001234_00005678);

        run_op(3'd3, 32'd20, 32'd3, 10, 64'h00000002_00000006, 1'b1);
        @(negedge clk);

        start = 1'b1; op = 3'd1; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hilo", {HI, LO}, 64'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("postrst_hilo", {HI, LO}, 64'd0);

        run_op(3'd2, 32'h00010000, 32'h00010000, 5,
               64'h00000001_00000000, 1'b0);
        repeat (3) @(negedge clk);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
